ifu_fetch: RTL and testbench
============================

Name: ifu_fetch

Overview:
Instruction fetch initiator that drives the instruction port of the physical memory model. It holds the PC, issues one word-aligned fetch request at a time, and captures returned instruction words into a small FIFO tagged with their PC. It presents them to decode over a valid/ready handshake. A redirect input (branch/jump/trap) flushes the FIFO and discards any response still in flight.

Parameters:
ADDR_WIDTH, 32, fetch address / PC width
DATA_WIDTH, 32, instruction word width
RESET_PC, 32'h8000_0000, PC loaded on reset (equals MEM_BASE)
FIFO_DEPTH, 4, instruction buffer entries (power of 2, >=2)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
req_o  out  1  fetch request valid
req_addr_o  out  ADDR_WIDTH  fetch address, word aligned
req_gnt_i  in  1  memory accepts request this cycle
rsp_valid_i  in  1  response data valid (>=1 cycle after grant)
rsp_data_i  in  DATA_WIDTH  instruction word
redirect_i  in  1  flush and restart fetch
redirect_pc_i  in  ADDR_WIDTH  new fetch PC
instr_valid_o  out  1  FIFO head valid
instr_o  out  DATA_WIDTH  head instruction
instr_pc_o  out  ADDR_WIDTH  PC of head instruction
instr_ready_i  in  1  decode consumes head

Behaviour:
- Reset (rst high at posedge) sets pc=RESET_PC, state=IDLE, FIFO empty. Outputs during and after the reset cycle: req_o=0 while rst high, instr_valid_o=0, instr_o=0, instr_pc_o=0. req_addr_o=RESET_PC. Reset mid-transaction abandons any in-flight request. The response arriving afterwards is ignored because state is IDLE.
- Internal state: fetch FSM (IDLE, WAIT, DROP), pc register, FIFO with count 0..FIFO_DEPTH, and an in-flight PC tag register.
- req_o = (state==IDLE) & (count<FIFO_DEPTH) & !redirect_i & !rst. This is combinational. req_addr_o = pc.
- IDLE: if req_o & req_gnt_i, latch tag=pc, pc<=pc+4 (wraps modulo 2^ADDR_WIDTH), go WAIT.
- WAIT: on rsp_valid_i, push {tag, rsp_data_i} and go IDLE. No new request is issued in the same cycle, so steady state is one request per 2 cycles.
- DROP: on rsp_valid_i, discard data and go IDLE.
- rsp_valid_i in IDLE is ignored.
- Space reservation: a request is issued only when count<FIFO_DEPTH. With one outstanding request, the push is guaranteed to fit even without pops. The FIFO never overflows.
- Pop: instr_valid_o = (count!=0). Head is popped when instr_valid_o & instr_ready_i. Simultaneous push and pop keeps count unchanged. Outputs are 0 when empty.
- Redirect (highest priority), when redirect_i is high at posedge:
  - pc<=redirect_pc_i with bits[1:0] forced to 0.
  - FIFO cleared (count=0); a same-cycle pop or push is ignored.
  - State: IDLE->IDLE; WAIT without rsp_valid_i -> DROP; WAIT with rsp_valid_i -> IDLE (response discarded); DROP stays DROP unless rsp_valid_i -> IDLE.
  - Because req_o is low while redirect_i is high, no grant can coincide with a redirect.
- The first request after a redirect occurs in the cycle after the redirect (IDLE), or after the dropped response arrives (DROP).
- instr_valid_o goes low the cycle after a redirect.

Test Plan:
- Reset release, memory grants immediately and responds 1 cycle later with words W0..W3, instr_ready_i=1 -> requests at 0x80000000, 0x80000004, 0x80000008, ... one every 2 cycles. Decode sees W0@0x80000000, W1@0x80000004, ... in order.
- instr_ready_i=0 with FIFO_DEPTH=4 -> exactly 4 requests, then req_o stays 0 and count=4. Raising ready for one cycle pops W0, and req_o reasserts the next cycle at 0x80000010.
- Redirect to 0x80000103 while in WAIT (grant given, response pending 3 cycles) -> FIFO empties next cycle. The pending response is dropped. The next req_addr_o is 0x80000100 and its data appears with instr_pc_o=0x80000100.
- redirect_i coincident with rsp_valid_i in WAIT and a head pop -> response discarded, pop ignored, count=0. Request to the new PC issued the following cycle.
- pc=0xFFFFFFFC fetch granted -> pc wraps to 0x00000000 and the next request is at address 0.
- Assert rst while in WAIT, deliver a response 2 cycles later -> response ignored, instr_valid_o=0, and the first post-reset request is at 0x80000000.

Source files
------------

// File: rtl/ifu_fetch_if.sv
// ----------------------------------------------------------------------------
// ifu_fetch_if
// Bundles the fetch unit's two handshakes: the instruction port towards the
// memory model (req/gnt/rsp) and the instruction stream towards decode
// (valid/ready), plus the redirect input.
//
// Signals:
//   req_o, req_addr_o         fetch request and word-aligned address
//   req_gnt_i                 memory accepts the request this cycle
//   rsp_valid_i, rsp_data_i   returned instruction word
//   redirect_i, redirect_pc_i flush and restart fetch at a new PC
//   instr_valid_o, instr_o,
//   instr_pc_o, instr_ready_i head of the instruction buffer to decode
//
// Modports:
//   master  the fetch unit
//   slave   memory/decode/redirect environment
// ----------------------------------------------------------------------------
interface ifu_fetch_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) ();
    logic                  req_o;
    logic [ADDR_WIDTH-1:0] req_addr_o;
    logic                  req_gnt_i;
    logic                  rsp_valid_i;
    logic [DATA_WIDTH-1:0] rsp_data_i;
    logic                  redirect_i;
    logic [ADDR_WIDTH-1:0] redirect_pc_i;
    logic                  instr_valid_o;
    logic [DATA_WIDTH-1:0] instr_o;
    logic [ADDR_WIDTH-1:0] instr_pc_o;
    logic                  instr_ready_i;

    modport master (
        output req_o, req_addr_o, instr_valid_o, instr_o, instr_pc_o,
        input  req_gnt_i, rsp_valid_i, rsp_data_i, redirect_i, redirect_pc_i,
               instr_ready_i
    );

    modport slave (
        input  req_o, req_addr_o, instr_valid_o, instr_o, instr_pc_o,
        output req_gnt_i, rsp_valid_i, rsp_data_i, redirect_i, redirect_pc_i,
               instr_ready_i
    );
endinterface

// File: rtl/ifu_fetch.sv
// ----------------------------------------------------------------------------
// ifu_fetch
// Instruction fetch initiator. Holds the PC, keeps at most one fetch in
// flight, and buffers returned words (tagged with their PC) in a small FIFO
// that decode drains over a valid/ready handshake. A redirect flushes the
// FIFO, reloads the PC and discards any response still outstanding.
//
// Ports:
//   clk   clock
//   rst   synchronous reset, active-high
//   bus   ifu_fetch_if.master (memory request/response, decode stream,
//         redirect)
// ----------------------------------------------------------------------------
module ifu_fetch #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h8000_0000,
    parameter int                    FIFO_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    ifu_fetch_if.master  bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // S_WAIT: a granted request awaits its response.
    // S_DROP: a redirect orphaned the outstanding request; swallow its response.
    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DROP
    } state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic [ADDR_WIDTH-1:0] tag_q;
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [CNT_W-1:0]      count_q;

    logic [DATA_WIDTH-1:0] data_mem [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] pc_mem   [FIFO_DEPTH];

    logic req;
    logic instr_valid;
    logic push;
    logic pop;
    logic fifo_full;

    assign fifo_full = (count_q == CNT_W'(FIFO_DEPTH));

    // A request is only issued while a slot is free, so the single
    // outstanding response always fits even if decode never pops.
    // NOTE: every signal driven from always_comb gets a default first so no latch is inferred.
    always_comb begin
        req         = 1'b0;
        instr_valid = 1'b0;
        push        = 1'b0;
        pop         = 1'b0;
        if (!rst) begin
            req         = (state_q == S_IDLE) && !fifo_full && !bus.redirect_i;
            instr_valid = (count_q != '0);
            push        = !bus.redirect_i && (state_q == S_WAIT) && bus.rsp_valid_i;
            pop         = !bus.redirect_i && instr_valid && bus.instr_ready_i;
        end
    end

    assign bus.req_o         = req;
    assign bus.req_addr_o    = pc_q;
    assign bus.instr_valid_o = instr_valid;
    assign bus.instr_o       = instr_valid ? data_mem[rd_ptr_q] : '0;
    assign bus.instr_pc_o    = instr_valid ? pc_mem[rd_ptr_q]   : '0;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            tag_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (bus.redirect_i) begin
            // Redirect wins over everything: same-cycle push/pop are dropped.
            pc_q     <= {bus.redirect_pc_i[ADDR_WIDTH-1:2], 2'b00};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            unique case (state_q)
                S_WAIT:  state_q <= bus.rsp_valid_i ? S_IDLE : S_DROP;
                S_DROP:  state_q <= bus.rsp_valid_i ? S_IDLE : S_DROP;
                default: state_q <= S_IDLE;
            endcase
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (req && bus.req_gnt_i) begin
                        tag_q   <= pc_q;
                        pc_q    <= pc_q + ADDR_WIDTH'(4);
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT, S_DROP: begin
                    if (bus.rsp_valid_i) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase

            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);

            unique case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: buffer storage has no reset; count_q alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr_q] <= bus.rsp_data_i;
            pc_mem[wr_ptr_q]   <= tag_q;
        end
    end
endmodule

// File: tb/tb_ifu_fetch.sv
// ----------------------------------------------------------------------------
// tb_ifu_fetch
// Directed bench for ifu_fetch. A behavioural memory grants when req_gnt_i is
// driven high and returns word_at(addr) a programmable number of cycles after
// each grant. Stimulus is driven at the falling edge and outputs are sampled
// 1 ns later, well away from the rising edge.
// ----------------------------------------------------------------------------
module tb_ifu_fetch;
    localparam int          AW       = 32;
    localparam int          DW       = 32;
    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    ifu_fetch_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    ifu_fetch #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .RESET_PC   (RESET_PC),
        .FIFO_DEPTH (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Memory model controls, written only by the main initial block.
    int   lat   = 1;
    logic flush = 1'b0;

    // Memory model state, written only by the responder.
    int          rsp_cnt = 0;
    logic [31:0] pend_addr = '0;
    logic        rsp_g;
    logic [31:0] rsp_a;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a ^ 32'h5A5A_A5A5;
    endfunction

    // Sample the grant at the rising edge (pre-edge values), then update the
    // response pipeline 1 ns later.
    always @(posedge clk) begin
        rsp_g = bus.req_o && bus.req_gnt_i;
        rsp_a = bus.req_addr_o;
        #1;
        bus.rsp_valid_i = 1'b0;
        if (flush) begin
            rsp_cnt = 0;
        end else begin
            if (rsp_cnt > 0) begin
                rsp_cnt = rsp_cnt - 1;
                if (rsp_cnt == 0) begin
                    bus.rsp_valid_i = 1'b1;
                    bus.rsp_data_i  = word_at(pend_addr);
                end
            end
            if (rsp_g) begin
                if (lat <= 1) begin
                    bus.rsp_valid_i = 1'b1;
                    bus.rsp_data_i  = word_at(rsp_a);
                end else begin
                    pend_addr = rsp_a;
                    rsp_cnt   = lat - 1;
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        flush             = 1'b1;
        rst               = 1'b1;
        bus.req_gnt_i     = 1'b0;
        bus.redirect_i    = 1'b0;
        bus.redirect_pc_i = '0;
        bus.instr_ready_i = 1'b0;
        repeat (2) @(negedge clk);
        rst   = 1'b0;
        flush = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst               = 1'b1;
        flush             = 1'b1;
        bus.req_gnt_i     = 1'b1;
        bus.redirect_i    = 1'b0;
        bus.redirect_pc_i = '0;
        bus.instr_ready_i = 1'b1;
        step();
        checks++; if (bus.req_o !== 1'b0) begin errors++; $display("FAIL reset_req_o: got %0b expected 0", bus.req_o); end
        checks++; if (bus.req_addr_o !== RESET_PC) begin errors++; $display("FAIL reset_req_addr: got %h expected %h", bus.req_addr_o, RESET_PC); end
        checks++; if (bus.instr_valid_o !== 1'b0) begin errors++; $display("FAIL reset_instr_valid: got %0b expected 0", bus.instr_valid_o); end
        checks++; if (bus.instr_o !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h expected 0", bus.instr_o); end
        checks++; if (bus.instr_pc_o !== 32'h0) begin errors++; $display("FAIL reset_instr_pc: got %h expected 0", bus.instr_pc_o); end
        @(negedge clk);
        bus.req_gnt_i = 1'b0;
        rst           = 1'b0;
        flush         = 1'b0;
        #1;
        checks++; if (bus.req_o !== 1'b1) begin errors++; $display("FAIL reset_release_req_o: got %0b expected 1", bus.req_o); end
    endtask

    task automatic test_stream();
        logic [31:0] exp_req;
        logic [31:0] exp_pop;
        int          npop;
        int          last;
        reset_dut();
        lat               = 1;
        bus.instr_ready_i = 1'b1;
        bus.req_gnt_i     = 1'b1;
        #1;
        exp_req = RESET_PC;
        exp_pop = RESET_PC;
        npop    = 0;
        last    = -1;
        for (int cyc = 0; cyc < 40 && npop < 4; cyc++) begin
            if (bus.req_o && bus.req_gnt_i) begin
                checks++; if (bus.req_addr_o !== exp_req) begin errors++; $display("FAIL stream_req_addr: got %h expected %h", bus.req_addr_o, exp_req); end
                if (last >= 0) begin
                    checks++; if (cyc - last != 2) begin errors++; $display("FAIL stream_req_spacing: got %0d cycles expected 2", cyc - last); end
                end
                last    = cyc;
                exp_req = exp_req + 32'd4;
            end
            if (bus.instr_valid_o && bus.instr_ready_i) begin
                checks++; if (bus.instr_pc_o !== exp_pop) begin errors++; $display("FAIL stream_instr_pc: got %h expected %h", bus.instr_pc_o, exp_pop); end
                checks++; if (bus.instr_o !== word_at(exp_pop)) begin errors++; $display("FAIL stream_instr: got %h expected %h", bus.instr_o, word_at(exp_pop)); end
                exp_pop = exp_pop + 32'd4;
                npop++;
            end
            step();
        end
        checks++; if (npop != 4) begin errors++; $display("FAIL stream_timeout: got %0d pops expected 4", npop); end
    endtask

    task automatic test_backpressure();
        int nreq;
        reset_dut();
        lat               = 1;
        bus.instr_ready_i = 1'b0;
        bus.req_gnt_i     = 1'b1;
        #1;
        nreq = 0;
        for (int c = 0; c < 20; c++) begin
            if (bus.req_o && bus.req_gnt_i) nreq++;
            step();
        end
        checks++; if (nreq != 4) begin errors++; $display("FAIL bp_req_count: got %0d expected 4", nreq); end
        checks++; if (bus.req_o !== 1'b0) begin errors++; $display("FAIL bp_full_req_o: got %0b expected 0", bus.req_o); end
        checks++; if (bus.instr_valid_o !== 1'b1) begin errors++; $display("FAIL bp_full_valid: got %0b expected 1", bus.instr_valid_o); end
        checks++; if (bus.instr_pc_o !== RESET_PC) begin errors++; $display("FAIL bp_head_pc: got %h expected %h", bus.instr_pc_o, RESET_PC); end
        checks++; if (bus.instr_o !== word_at(RESET_PC)) begin errors++; $display("FAIL bp_head_instr: got %h expected %h", bus.instr_o, word_at(RESET_PC)); end
        @(negedge clk);
        bus.instr_ready_i = 1'b1;
        #1;
        checks++; if (bus.req_o !== 1'b0) begin errors++; $display("FAIL bp_pop_cycle_req_o: got %0b expected 0", bus.req_o); end
        @(negedge clk);
        bus.instr_ready_i = 1'b0;
        #1;
        checks++; if (bus.req_o !== 1'b1) begin errors++; $display("FAIL bp_reassert_req_o: got %0b expected 1", bus.req_o); end
        checks++; if (bus.req_addr_o !== 32'h8000_0010) begin errors++; $display("FAIL bp_reassert_addr: got %h expected 80000010", bus.req_addr_o); end
        checks++; if (bus.instr_pc_o !== 32'h8000_0004) begin errors++; $display("FAIL bp_new_head_pc: got %h expected 80000004", bus.instr_pc_o); end
    endtask

    task automatic test_redirect_wait();
        int  nreq;
        int  w;
        reset_dut();
        lat               = 1;
        bus.instr_ready_i = 1'b0;
        bus.req_gnt_i     = 1'b1;
        #1;
        nreq = 0;
        for (int c = 0; c < 20 && nreq < 3; c++) begin
            if (bus.req_o && bus.req_gnt_i) begin
                nreq++;
                if (nreq == 3) lat = 3;
            end
            if (nreq < 3) step();
        end
        checks++; if (nreq != 3) begin errors++; $display("FAIL rw_setup_timeout: got %0d requests expected 3", nreq); end
        step();
        @(negedge clk);
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'h8000_0103;
        #1;
        checks++; if (bus.instr_valid_o !== 1'b1) begin errors++; $display("FAIL rw_valid_before: got %0b expected 1", bus.instr_valid_o); end
        checks++; if (bus.req_o !== 1'b0) begin errors++; $display("FAIL rw_req_during_redirect: got %0b expected 0", bus.req_o); end
        @(negedge clk);
        bus.redirect_i = 1'b0;
        #1;
        checks++; if (bus.instr_valid_o !== 1'b0) begin errors++; $display("FAIL rw_valid_after: got %0b expected 0", bus.instr_valid_o); end
        checks++; if (bus.req_o !== 1'b0) begin errors++; $display("FAIL rw_drop_req_o: got %0b expected 0", bus.req_o); end
        w = 0;
        while (!(bus.req_o && bus.req_gnt_i) && w < 10) begin
            step();
            w++;
            checks++; if (bus.instr_valid_o !== 1'b0) begin errors++; $display("FAIL rw_dropped_pushed: got valid %0b expected 0", bus.instr_valid_o); end
        end
        checks++; if (bus.req_addr_o !== 32'h8000_0100) begin errors++; $display("FAIL rw_new_req_addr: got %h expected 80000100", bus.req_addr_o); end
        bus.instr_ready_i = 1'b1;
        w = 0;
        while (!bus.instr_valid_o && w < 12) begin
            step();
            w++;
        end
        checks++; if (bus.instr_pc_o !== 32'h8000_0100) begin errors++; $display("FAIL rw_new_instr_pc: got %h expected 80000100", bus.instr_pc_o); end
        checks++; if (bus.instr_o !== word_at(32'h8000_0100)) begin errors++; $display("FAIL rw_new_instr: got %h expected %h", bus.instr_o, word_at(32'h8000_0100)); end
    endtask

    task automatic test_redirect_rsp_pop();
        int nreq;
        int w;
        reset_dut();
        lat               = 1;
        bus.instr_ready_i = 1'b0;
        bus.req_gnt_i     = 1'b1;
        #1;
        nreq = 0;
        for (int c = 0; c < 20 && nreq < 2; c++) begin
            if (bus.req_o && bus.req_gnt_i) nreq++;
            if (nreq < 2) step();
        end
        @(negedge clk);
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'h0000_1000;
        bus.instr_ready_i = 1'b1;
        #1;
        checks++; if (bus.rsp_valid_i !== 1'b1 || bus.instr_valid_o !== 1'b1) begin errors++; $display("FAIL rp_setup: got rsp_valid %0b instr_valid %0b expected 1 1", bus.rsp_valid_i, bus.instr_valid_o); end
        @(negedge clk);
        bus.redirect_i    = 1'b0;
        bus.instr_ready_i = 1'b0;
        #1;
        checks++; if (bus.instr_valid_o !== 1'b0) begin errors++; $display("FAIL rp_valid_after: got %0b expected 0", bus.instr_valid_o); end
        checks++; if (bus.req_o !== 1'b1) begin errors++; $display("FAIL rp_req_o_next: got %0b expected 1", bus.req_o); end
        checks++; if (bus.req_addr_o !== 32'h0000_1000) begin errors++; $display("FAIL rp_req_addr_next: got %h expected 00001000", bus.req_addr_o); end
        w = 0;
        while (!bus.instr_valid_o && w < 10) begin
            step();
            w++;
        end
        checks++; if (bus.instr_pc_o !== 32'h0000_1000) begin errors++; $display("FAIL rp_new_instr_pc: got %h expected 00001000", bus.instr_pc_o); end
        checks++; if (bus.instr_o !== word_at(32'h0000_1000)) begin errors++; $display("FAIL rp_new_instr: got %h expected %h", bus.instr_o, word_at(32'h0000_1000)); end
    endtask

    task automatic test_wrap();
        logic seen;
        int   w;
        reset_dut();
        lat               = 1;
        bus.instr_ready_i = 1'b1;
        @(negedge clk);
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'hFFFF_FFFF;
        @(negedge clk);
        bus.redirect_i    = 1'b0;
        bus.req_gnt_i     = 1'b1;
        #1;
        checks++; if (bus.req_o !== 1'b1 || bus.req_addr_o !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_first_req: got req %0b addr %h expected 1 fffffffc", bus.req_o, bus.req_addr_o); end
        step();
        seen = 1'b0;
        w    = 0;
        while (w < 10) begin
            if (bus.instr_valid_o && !seen) begin
                seen = 1'b1;
                checks++; if (bus.instr_pc_o !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_instr_pc: got %h expected fffffffc", bus.instr_pc_o); end
            end
            if (bus.req_o && bus.req_gnt_i) break;
            step();
            w++;
        end
        checks++; if (bus.req_addr_o !== 32'h0000_0000) begin errors++; $display("FAIL wrap_next_addr: got %h expected 00000000", bus.req_addr_o); end
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL wrap_instr_seen: got %0b expected 1", seen); end
    endtask

    task automatic test_reset_midwait();
        int w;
        reset_dut();
        lat               = 3;
        bus.instr_ready_i = 1'b1;
        bus.req_gnt_i     = 1'b1;
        #1;
        checks++; if (bus.req_o !== 1'b1) begin errors++; $display("FAIL rm_first_req: got %0b expected 1", bus.req_o); end
        @(negedge clk);
        bus.req_gnt_i = 1'b0;
        rst           = 1'b1;
        #1;
        checks++; if (bus.req_o !== 1'b0) begin errors++; $display("FAIL rm_req_in_reset: got %0b expected 0", bus.req_o); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (bus.req_addr_o !== RESET_PC) begin errors++; $display("FAIL rm_pc_after_reset: got %h expected %h", bus.req_addr_o, RESET_PC); end
        for (int c = 0; c < 4; c++) begin
            step();
            checks++; if (bus.instr_valid_o !== 1'b0) begin errors++; $display("FAIL rm_stale_pushed: got valid %0b expected 0", bus.instr_valid_o); end
        end
        @(negedge clk);
        bus.req_gnt_i = 1'b1;
        #1;
        checks++; if (bus.req_o !== 1'b1 || bus.req_addr_o !== RESET_PC) begin errors++; $display("FAIL rm_post_reset_req: got req %0b addr %h expected 1 %h", bus.req_o, bus.req_addr_o, RESET_PC); end
        w = 0;
        while (!bus.instr_valid_o && w < 12) begin
            step();
            w++;
        end
        checks++; if (bus.instr_pc_o !== RESET_PC) begin errors++; $display("FAIL rm_instr_pc: got %h expected %h", bus.instr_pc_o, RESET_PC); end
        checks++; if (bus.instr_o !== word_at(RESET_PC)) begin errors++; $display("FAIL rm_instr: got %h expected %h", bus.instr_o, word_at(RESET_PC)); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.req_gnt_i     = 1'b0;
        bus.redirect_i    = 1'b0;
        bus.redirect_pc_i = '0;
        bus.instr_ready_i = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_wait();
        test_redirect_rsp_pop();
        test_wrap();
        test_reset_midwait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
